// File: rtl/dht_ctrl_pkg.sv
// Shared constants for the multi-channel DHT11 controller: opcodes, response codes,
// FSM states and the byte layout of a 40-bit sensor frame.
package dht_ctrl_pkg;

    localparam logic [3:0] OP_STATUS    = 4'd0;
    localparam logic [3:0] OP_TEMP_INT  = 4'd1;
    localparam logic [3:0] OP_HUM_INT   = 4'd2;
    localparam logic [3:0] OP_TEMP_FRAC = 4'd3;
    localparam logic [3:0] OP_HUM_FRAC  = 4'd4;
    localparam logic [3:0] OP_MAX       = OP_HUM_FRAC;

    localparam logic [7:0] RC_STATUS      = 8'h1F;
    localparam logic [7:0] RC_TEMP_INT    = 8'h01;
    localparam logic [7:0] RC_HUM_INT     = 8'h02;
    localparam logic [7:0] RC_TEMP_FRAC   = 8'h03;
    localparam logic [7:0] RC_HUM_FRAC    = 8'h04;
    localparam logic [7:0] RC_ERR_SENSOR  = 8'hE0;
    localparam logic [7:0] RC_ERR_TIMEOUT = 8'hE1;
    localparam logic [7:0] RC_ERR_OPCODE  = 8'hE2;
    localparam logic [7:0] RC_ERR_ADDR    = 8'hE3;
    localparam logic [7:0] RC_ERR_CHKSUM  = 8'hE4;

    localparam int FRAME_W       = 40;
    localparam int HUM_INT_LSB   = 32;
    localparam int HUM_FRAC_LSB  = 24;
    localparam int TEMP_INT_LSB  = 16;
    localparam int TEMP_FRAC_LSB = 8;
    localparam int CHK_LSB       = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_COLLECT,
        S_RESPOND,
        S_RELEASE
    } state_t;

    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input int lsb);
        return f[lsb +: 8];
    endfunction

endpackage

// File: rtl/dht_frame_decode.sv
// Combinational opcode/frame -> {code,data}; checksum enforced only when DHT_CHECKSUM_EN is defined.
// Latency: 0 cycles. No flow control; pure function of its inputs.
module dht_frame_decode
    import dht_ctrl_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [3:0]         op_i,
    output logic [7:0]         code_o,
    output logic [7:0]         data_o
);

    logic chk_ok;

`ifdef DHT_CHECKSUM_EN
    logic [7:0] chk_sum;
    assign chk_sum = frame_byte(frame_i, HUM_INT_LSB) + frame_byte(frame_i, HUM_FRAC_LSB)
                   + frame_byte(frame_i, TEMP_INT_LSB) + frame_byte(frame_i, TEMP_FRAC_LSB);
    assign chk_ok  = (chk_sum == frame_byte(frame_i, CHK_LSB));
`else
    logic unused_chk;
    assign unused_chk = ^frame_i[CHK_LSB +: 8];
    assign chk_ok     = 1'b1;
`endif

    always_comb begin
        code_o = RC_ERR_OPCODE;
        data_o = 8'h00;
        case (op_i)
            OP_STATUS:    begin code_o = RC_STATUS;    data_o = 8'h00; end
            OP_TEMP_INT:  begin code_o = RC_TEMP_INT;  data_o = frame_byte(frame_i, TEMP_INT_LSB); end
            OP_HUM_INT:   begin code_o = RC_HUM_INT;   data_o = frame_byte(frame_i, HUM_INT_LSB); end
            OP_TEMP_FRAC: begin code_o = RC_TEMP_FRAC; data_o = frame_byte(frame_i, TEMP_FRAC_LSB); end
            OP_HUM_FRAC:  begin code_o = RC_HUM_FRAC;  data_o = frame_byte(frame_i, HUM_FRAC_LSB); end
            default:      begin code_o = RC_ERR_OPCODE; data_o = 8'h00; end
        endcase
        // A corrupt frame overrides every opcode's result.
        if (!chk_ok) begin
            code_o = RC_ERR_CHKSUM;
            data_o = 8'h00;
        end
    end

endmodule

// File: rtl/dht_multi_ctrl.sv
// Multi-channel DHT11 command controller: one acquisition per command, response held until ack.
// Latency: done->resp_valid 1 cycle; optional checksum check under DHT_CHECKSUM_EN.
// Backpressure: response held stable until resp_ack; a held command runs once (re-arm on valid=0).
module dht_multi_ctrl
    import dht_ctrl_pkg::*;
#(
    parameter int N_SENSORS      = 32,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  cmd_in,
    input  logic                         resp_ack,
    input  logic [N_SENSORS*FRAME_W-1:0] sensor_frame,
    input  logic [N_SENSORS-1:0]         sensor_done,
    input  logic [N_SENSORS-1:0]         sensor_err,
    output logic [N_SENSORS-1:0]         sensor_en,
    output logic [N_SENSORS-1:0]         sensor_rst,
    output logic                         resp_valid,
    output logic [15:0]                  resp_data,
    output logic                         busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                 state_q;
    logic                   armed_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [3:0]             op_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [N_SENSORS-1:0]   en_q;
    logic [N_SENSORS-1:0]   rst_q;
    logic                   rv_q;
    logic [15:0]            rdata_q;

    logic                   cmd_vld;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [3:0]             cmd_op;
    logic                   cmd_addr_ok;
    logic [N_SENSORS-1:0]   addr_sel;
    logic [FRAME_W-1:0]     sel_frame;
    logic                   sel_done;
    logic                   sel_err;
    logic                   timeout;
    logic [7:0]             dec_code;
    logic [7:0]             dec_data;
    logic                   unused_cmd;

    function automatic logic [N_SENSORS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [N_SENSORS-1:0] r;
        r = '0;
        for (int i = 0; i < N_SENSORS; i++) r[i] = (a == ADDR_W'(i));
        return r;
    endfunction

    assign cmd_vld     = cmd_in[15];
    assign cmd_addr    = cmd_in[4 +: ADDR_W];
    assign cmd_op      = cmd_in[3:0];
    assign cmd_addr_ok = {{(32-ADDR_W){1'b0}}, cmd_addr} < 32'(N_SENSORS);
    assign unused_cmd  = ^cmd_in[14:9];

    // Only the latched channel's done/err/frame are visible to the FSM.
    always_comb begin
        addr_sel  = onehot(addr_q);
        sel_frame = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (addr_sel[i]) sel_frame = sensor_frame[i*FRAME_W +: FRAME_W];
        end
    end

    assign sel_done = |(sensor_done & addr_sel);
    assign sel_err  = |(sensor_err & addr_sel);
    assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    dht_frame_decode u_decode (
        .frame_i (sel_frame),
        .op_i    (op_q),
        .code_o  (dec_code),
        .data_o  (dec_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b1;
            addr_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            rst_q   <= '1;
            rv_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (!cmd_vld) armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (cmd_vld && armed_q) begin
                        armed_q <= 1'b0;
                        addr_q  <= cmd_addr;
                        op_q    <= cmd_op;
                        if (!cmd_addr_ok) begin
                            state_q <= S_RESPOND;
                            rv_q    <= 1'b1;
                            rdata_q <= {RC_ERR_ADDR, 8'h00};
                        end else if (cmd_op > OP_MAX) begin
                            state_q <= S_RESPOND;
                            rv_q    <= 1'b1;
                            rdata_q <= {RC_ERR_OPCODE, 8'h00};
                        end else begin
                            state_q <= S_START;
                            en_q    <= onehot(cmd_addr);
                            rst_q   <= ~onehot(cmd_addr);
                            cnt_q   <= '0;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_COLLECT;
                    cnt_q   <= '0;
                end
                S_COLLECT: begin
                    if (sel_err || sel_done || timeout) begin
                        state_q <= S_RESPOND;
                        en_q    <= '0;
                        rv_q    <= 1'b1;
                        if (sel_err)       rdata_q <= {RC_ERR_SENSOR, 8'h00};
                        else if (sel_done) rdata_q <= {dec_code, dec_data};
                        else               rdata_q <= {RC_ERR_TIMEOUT, 8'h00};
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESPOND: begin
                    if (resp_ack) begin
                        state_q <= S_RELEASE;
                        rv_q    <= 1'b0;
                        rdata_q <= '0;
                        rst_q   <= '1;
                    end
                end
                S_RELEASE: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    assign sensor_en  = en_q;
    assign sensor_rst = rst_q;
    assign resp_valid = rv_q;
    assign resp_data  = rdata_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dht_multi_ctrl.sv
// Scoreboard bench for dht_multi_ctrl (4 channels, 100-cycle timeout); expected responses are
// queued when stimulus is driven and checked when resp_valid rises.
module tb_dht_multi_ctrl;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int TO = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       cmd_in;
    logic              resp_ack;
    logic [N*40-1:0]   sensor_frame;
    logic [N-1:0]      sensor_done;
    logic [N-1:0]      sensor_err;
    logic [N-1:0]      sensor_en;
    logic [N-1:0]      sensor_rst;
    logic              resp_valid;
    logic [15:0]       resp_data;
    logic              busy;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          n_resp = 0;
    logic [15:0] sb[$];
    logic        rv_prev = 1'b0;
    logic [15:0] held    = 16'h0;

    always #5 clk = ~clk;

    dht_multi_ctrl #(
        .N_SENSORS      (N),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .resp_ack     (resp_ack),
        .sensor_frame (sensor_frame),
        .sensor_done  (sensor_done),
        .sensor_err   (sensor_err),
        .sensor_en    (sensor_en),
        .sensor_rst   (sensor_rst),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pop on the rising edge of resp_valid, then require a stable word.
    always @(negedge clk) begin
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            if (resp_valid && !rv_prev) begin
                n_resp++;
                if (sb.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'd0);
                else                check("resp", 32'(resp_data), 32'(sb.pop_front()));
                held = resp_data;
            end else if (resp_valid) begin
                check("hold", 32'(resp_data), 32'(held));
            end
            rv_prev = resp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input string tag, input int bound, output int n);
        n = 0;
        while (!resp_valid && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(resp_valid), 32'd1);
    endtask

    task automatic ack_resp();
        int n;
        wait_rv("rv_wait", 20, n);
        repeat (2) tick();
        resp_ack = 1'b1;
        tick();
        resp_ack = 1'b0;
        check("rel_rv", 32'(resp_valid), 32'd0);
        check("rel_data", 32'(resp_data), 32'd0);
        check("rel_rst", 32'(sensor_rst), 32'hF);
        tick();
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic acq(input logic [15:0] cmd, input int ch, input logic [39:0] f,
                       input logic [15:0] exp, input bit hold);
        logic [N-1:0] m;
        logic [N-1:0] mr;
        m  = N'(1 << ch);
        mr = ~m;
        cmd_in = cmd;
        tick();
        check("start_en", 32'(sensor_en), 32'(m));
        check("start_rst", 32'(sensor_rst), 32'(mr));
        check("start_busy", 32'(busy), 32'd1);
        if (!hold) cmd_in = 16'h0;
        tick();
        sensor_frame[ch*40 +: 40] = f;
        sensor_done[ch] = 1'b1;
        sb.push_back(exp);
        tick();
        check("lat_rv", 32'(resp_valid), 32'd1);
        check("lat_en", 32'(sensor_en), 32'd0);
        sensor_done = '0;
        ack_resp();
    endtask

    initial begin
        logic [15:0] op_exp[5];
        logic [15:0] e6;
        int          r0;
        int          n;

        op_exp = '{16'h1F00, 16'h0117, 16'h022A, 16'h0308, 16'h0405};
        reset = 1'b1; cmd_in = '0; resp_ack = 1'b0;
        sensor_frame = '0; sensor_done = '0; sensor_err = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 32'(sensor_en), 32'd0);
        check("rst_srst", 32'(sensor_rst), 32'hF);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // T1: channel 1 temperature integer
        acq(16'h8011, 1, 40'h3700190050, 16'h0119, 1'b0);

        // Every opcode on channel 3
        for (int op = 0; op < 5; op++)
            acq(16'h8030 | 16'(op), 3, 40'h2A0517084E, op_exp[op], 1'b0);

        // T2: held command executes once, re-arms after valid drops
        r0 = n_resp;
        acq(16'h8002, 0, 40'h3700190050, 16'h0237, 1'b1);
        repeat (5) tick();
        check("t2_no_rerun_en", 32'(sensor_en), 32'd0);
        check("t2_no_rerun_busy", 32'(busy), 32'd0);
        check("t2_once", 32'(n_resp - r0), 32'd1);
        cmd_in = 16'h0;
        tick();
        acq(16'h8002, 0, 40'h3700190050, 16'h0237, 1'b0);
        check("t2_twice", 32'(n_resp - r0), 32'd2);

        // T3: bad address, bad opcode
        sb.push_back(16'hE300);
        cmd_in = 16'h81F1;
        tick();
        check("t3_addr_rv", 32'(resp_valid), 32'd1);
        check("t3_addr_en", 32'(sensor_en), 32'd0);
        cmd_in = 16'h0;
        ack_resp();
        sb.push_back(16'hE200);
        cmd_in = 16'h8009;
        tick();
        check("t3_op_rv", 32'(resp_valid), 32'd1);
        check("t3_op_en", 32'(sensor_en), 32'd0);
        cmd_in = 16'h0;
        ack_resp();

        // T4: timeout on channel 2
        cmd_in = 16'h8021;
        tick();
        check("t4_start_en", 32'(sensor_en), 32'h4);
        cmd_in = 16'h0;
        sb.push_back(16'hE100);
        wait_rv("t4_rv", 300, n);
        check("t4_cycles", 32'(n), 32'(TO + 1));
        check("t4_en", 32'(sensor_en), 32'd0);
        ack_resp();
        check("t4_en_after", 32'(sensor_en[2]), 32'd0);

        // T5: foreign done ignored; err wins over done
        cmd_in = 16'h8001;
        tick();
        check("t5_start_en", 32'(sensor_en), 32'h1);
        cmd_in = 16'h0;
        tick();
        sensor_frame[3*40 +: 40] = 40'h2A0517084E;
        sensor_done[3] = 1'b1;
        sensor_err[2]  = 1'b1;
        repeat (2) tick();
        check("t5_ignore_rv", 32'(resp_valid), 32'd0);
        check("t5_ignore_en", 32'(sensor_en), 32'h1);
        sensor_done = '0;
        sensor_err  = '0;
        sensor_done[0] = 1'b1;
        sensor_err[0]  = 1'b1;
        sb.push_back(16'hE000);
        tick();
        check("t5_rv", 32'(resp_valid), 32'd1);
        sensor_done = '0;
        sensor_err  = '0;
        ack_resp();

        // T6: bad checksum byte
`ifdef DHT_CHECKSUM_EN
        e6 = 16'hE400;
`else
        e6 = 16'h0119;
`endif
        acq(16'h8011, 1, 40'h370019004F, e6, 1'b0);

        // T6: reset while collecting
        cmd_in = 16'h8012;
        tick();
        cmd_in = 16'h0;
        tick();
        sensor_frame[1*40 +: 40] = 40'h3700190050;
        #2;
        reset = 1'b1;
        sensor_done[1] = 1'b1;
        #1;
        check("t6_rst_en", 32'(sensor_en), 32'd0);
        check("t6_rst_srst", 32'(sensor_rst), 32'hF);
        check("t6_rst_rv", 32'(resp_valid), 32'd0);
        check("t6_rst_data", 32'(resp_data), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sensor_done = '0;
        repeat (5) tick();
        check("t6_post_rv", 32'(resp_valid), 32'd0);
        check("t6_post_busy", 32'(busy), 32'd0);
        acq(16'h8013, 1, 40'h3700190050, 16'h0300, 1'b0);

        check("sb_left", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
